// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART blocks.
// Line parity, transmitter states and bit-period math.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int cpb_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, 0..CPB-1.
// tick marks the last clock of each bit period.
module uart_baud_cnt #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W = (CPB > 1) ? $clog2(CPB) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(CPB - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: parametrised UART transmitter, one word per handshake.
// Frame: start, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int      CLK_HZ    = 100_000_000,
  parameter int      BAUD      = 9600,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CPB     = cpb_calc(CLK_HZ, BAUD);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_core: CPB %0d is below 2", CPB);
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_dw
    $error("uart_tx_core: DATA_BITS %0d outside 5..9", DATA_BITS);
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_core: STOP_BITS %0d not 1 or 2", STOP_BITS);
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bitcnt;
  logic                 stopcnt;
  logic                 par;
  logic                 tick;

  // Held clear in IDLE so every frame starts on a fresh period.
  uart_baud_cnt #(
    .CPB(CPB)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state == S_IDLE),
    .en   (state != S_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      stopcnt  <= 1'b0;
      par      <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          txd      <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            par      <= (PARITY == PAR_ODD) ? ~(^tx_data) : ^tx_data;
            state    <= S_START;
            txd      <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            state  <= S_DATA;
            txd    <= shreg[0];
            bitcnt <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bitcnt == 4'(DATA_BITS - 1)) begin
              if (HAS_PAR) begin
                state <= S_PARITY;
                txd   <= par;
              end else begin
                state   <= S_STOP;
                txd     <= 1'b1;
                stopcnt <= 1'b0;
              end
            end else begin
              bitcnt <= bitcnt + 4'd1;
              shreg  <= shreg >> 1;
              txd    <= shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state   <= S_STOP;
            txd     <= 1'b1;
            stopcnt <= 1'b0;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (stopcnt == 1'(STOP_BITS - 1)) begin
              state    <= S_IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              stopcnt <= stopcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed frame checks over several configurations.
// Cycle n is the clock interval after edge n-1; edge 0 is the handshake.
module tb_uart_tx_core;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] vld, rdy, txd, busy, done;
  logic [7:0] d8;
  logic [4:0] d5;
  logic [8:0] d9;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000),
    .PARITY(PAR_EVEN), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000),
    .PARITY(PAR_ODD)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000),
    .DATA_BITS(5)) u3 (
    .clk(clk), .rst_n(rst_n), .tx_data(d5), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  uart_tx_core #(.CLK_HZ(1_000_000), .BAUD(100_000),
    .DATA_BITS(9)) u4 (
    .clk(clk), .rst_n(rst_n), .tx_data(d9), .tx_valid(vld[4]),
    .tx_ready(rdy[4]), .txd(txd[4]), .tx_busy(busy[4]), .tx_done(done[4]));

  uart_tx_core u5 (
    .clk(clk), .rst_n(rst_n), .tx_data(d8), .tx_valid(vld[5]),
    .tx_ready(rdy[5]), .txd(txd[5]), .tx_busy(busy[5]), .tx_done(done[5]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cur < c) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic send(input int i, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("u%0d_rdy", i), 32'(rdy[i]), 1);
    vld[i] = 1'b1;
    @(posedge clk);
    cur = 0;
    if (!hold) #1 vld[i] = 1'b0;
  endtask

  task automatic frame(input int i, input int cpb, input logic [15:0] exp,
                       input int f, input int nchk);
    to_cyc(1);
    check($sformatf("u%0d_busy1", i), 32'(busy[i]), 1);
    check($sformatf("u%0d_rdy1", i), 32'(rdy[i]), 0);
    for (int j = 0; j < nchk; j++) begin
      to_cyc(j * cpb + 1);
      check($sformatf("u%0d_b%0d_first", i, j), 32'(txd[i]), 32'(exp[j]));
      to_cyc((j + 1) * cpb);
      check($sformatf("u%0d_b%0d_last", i, j), 32'(txd[i]), 32'(exp[j]));
    end
    if (nchk == f) begin
      check($sformatf("u%0d_done_early", i), 32'(done[i]), 0);
      to_cyc(f * cpb + 1);
      check($sformatf("u%0d_done", i), 32'(done[i]), 1);
      check($sformatf("u%0d_busy_end", i), 32'(busy[i]), 0);
      check($sformatf("u%0d_rdy_end", i), 32'(rdy[i]), 1);
      check($sformatf("u%0d_idle_txd", i), 32'(txd[i]), 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    vld = '0;
    d8 = '0;
    d5 = '0;
    d9 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(txd[0]), 1);
    check("rst_rdy", 32'(rdy[0]), 0);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", 32'(rdy[0]), 1);

    // 8N1 0xEF: 0,1,1,1,1,0,1,1,1,1
    d8 = 8'hEF;
    send(0, 1'b0);
    frame(0, 10, 16'b00000_0_1111_0111_1 >> 1 | 16'h0000, 10, 0);
    cur = cur;
    frame(0, 10, 16'(10'b1111011110), 10, 10);

    // 8E2 0xEF: seven ones, parity 1
    d8 = 8'hEF;
    send(1, 1'b0);
    frame(1, 10, 16'(12'b11_1_11101111_0), 12, 12);

    // 8O1 0xEF: parity 0; a pulse of tx_valid mid-frame is ignored
    d8 = 8'hEF;
    send(2, 1'b0);
    fork
      begin
        #300 vld[2] = 1'b1;
        d8 = 8'h00;
        #10 vld[2] = 1'b0;
      end
    join_none
    frame(2, 10, 16'(11'b1_0_11101111_0), 11, 11);
    to_cyc(113);
    check("u2_no_queue", 32'(busy[2]), 0);

    // 5N1 0x1F then 0x0B (LSB first: 1,1,0,1,0)
    d5 = 5'h1F;
    send(3, 1'b0);
    frame(3, 10, 16'(7'b1_11111_0), 7, 7);
    d5 = 5'h0B;
    send(3, 1'b0);
    frame(3, 10, 16'(7'b1_01011_0), 7, 7);

    // 9N1 0x1AA
    d9 = 9'h1AA;
    send(4, 1'b0);
    frame(4, 10, 16'(11'b1_110101010_0), 11, 11);

    // Back-to-back A5, 3C, FF with data changed mid-frame
    d8 = 8'hA5;
    send(0, 1'b1);
    fork
      begin
        #500 d8 = 8'h3C;
        #1000 d8 = 8'hFF;
        #1000 begin
          vld[0] = 1'b0;
          d8 = 8'h00;
        end
      end
    join_none
    frame(0, 10, 16'(10'b1_10100101_0), 10, 10);
    cur = 0;
    frame(0, 10, 16'(10'b1_00111100_0), 10, 10);
    cur = 0;
    frame(0, 10, 16'(10'b1_11111111_0), 10, 10);
    to_cyc(103);
    check("b2b_stop_busy", 32'(busy[0]), 0);
    check("b2b_stop_txd", 32'(txd[0]), 1);

    // Reset during data bit 3 of 0xF7 (that bit is 0)
    d8 = 8'hF7;
    send(0, 1'b0);
    to_cyc(45);
    check("pre_rst_txd", 32'(txd[0]), 0);
    rst_n = 1'b0;
    to_cyc(46);
    check("abort_txd", 32'(txd[0]), 1);
    check("abort_busy", 32'(busy[0]), 0);
    check("abort_rdy", 32'(rdy[0]), 0);
    check("abort_done", 32'(done[0]), 0);
    rst_n = 1'b1;
    to_cyc(47);
    check("abort_rdy_rel", 32'(rdy[0]), 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      to_cyc(48 + k);
      if (done[0]) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 0);
    d8 = 8'h5A;
    send(0, 1'b0);
    frame(0, 10, 16'(10'b1_01011010_0), 10, 10);

    // Default 100 MHz / 9600: CPB 10417; start and first two data bits
    d8 = 8'hEF;
    send(5, 1'b0);
    frame(5, 10417, 16'(10'b1_11101111_0), 10, 3);
    to_cyc(10417 + 1);
    check("dflt_start_over", 32'(txd[5]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmitter that serialises one word per valid/ready handshake onto a single `txd` line, with configurable baud rate, data width, parity and stop bits. It replaces the fixed 8N1, button-triggered transmitter. It sits between the game-state logic or any byte producer and the board's serial output pin, and is driven from the 100 MHz system clock.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `DATA_BITS`, 8: payload width, legal range 5..9.
- `PARITY`, `PAR_NONE`: one of `PAR_NONE`, `PAR_ODD`, `PAR_EVEN` (`uart_pkg::parity_t`).
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `tx_data`  in  DATA_BITS  word to send; sampled only on handshake.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  transmitter can accept a word (high only in IDLE).
- `txd`  out  1  serial line; idle/mark = 1.
- `tx_busy`  out  1  frame in progress (= not IDLE).
- `tx_done`  out  1  one-cycle pulse after the last stop bit completes.

## Operation
- Bit period: `CPB = (CLK_HZ + BAUD/2) / BAUD`, rounded to nearest. Defaults give 10417. Elaboration `$error` if CPB < 2, DATA_BITS is outside 5..9, or STOP_BITS is not 1 or 2.
- Frame: 1 start bit (0), DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits (1). Frame length `F = 1 + DATA_BITS + (PARITY != PAR_NONE) + STOP_BITS`.
- Parity: even parity means the parity bit equals the XOR of the data bits. Odd parity means it equals the inverted XOR. It is computed from the captured word, not the live `tx_data`.
- FSM states: IDLE → START → DATA → (PARITY if enabled) → STOP → IDLE.
  - IDLE: `txd=1`, `tx_ready=1`. `tx_valid & tx_ready` captures `tx_data` into the shift register and enters START.
  - START: `txd=0` for CPB cycles.
  - DATA: shift right once per bit period; `txd` = shift register LSB. A bit counter runs 0..DATA_BITS-1.
  - PARITY: `txd` = parity bit for CPB cycles.
  - STOP: `txd=1` for STOP_BITS×CPB cycles; `tx_done` pulses on exit to IDLE.
- Baud counter counts 0..CPB-1 and is cleared on every state entry. A state or bit advance occurs when the count is CPB-1.
- Changes to `tx_data` after the handshake have no effect on the frame in flight. `tx_valid` while busy is ignored (no capture, no queueing).
- Reset: while `rst_n=0` at a clock edge, the block goes to IDLE with `txd=1`, `tx_ready=0`, `tx_busy=0`, `tx_done=0`, and counters and shift register at 0. `tx_ready=1` on the first cycle after release. Reset mid-frame aborts the frame immediately: line returns to 1 at the next edge, no `tx_done`.

## Timing
- Handshake on edge 0 → `txd=0` from cycle 1 through cycle CPB.
- Data bit k occupies cycles `(1+k)·CPB+1` .. `(2+k)·CPB`.
- Last stop bit ends at cycle F·CPB. IDLE, `tx_ready=1` and `tx_done=1` all occur at cycle F·CPB+1.
- Back-to-back: if `tx_valid` is held, the next handshake is at cycle F·CPB+1 and the next start bit begins at F·CPB+2. This guarantees exactly one idle clock between frames.
- Every output is registered; none depends combinationally on `tx_valid` or `tx_data`.

## Structure
- `uart_pkg`: `parity_t` enum (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`), `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP), and the function `cpb_calc(CLK_HZ, BAUD)`. A future RX block shares this package.
- Sub-module `uart_baud_cnt`, parametrised on CPB:
  - inputs `clear`, `en`; output `tick` when count = CPB-1.
  - counter width is `$clog2(CPB)`.
- FSM, shift register, bit counter, stop counter and parity live in the top module.

## Test plan
- 8N1, CLK_HZ=1_000_000, BAUD=100_000 (CPB=10): send 8'hEF → line reads 0,1,1,1,1,0,1,1,1,1 with each bit 10 cycles wide. `tx_done` at cycle 101. `tx_busy` is low again at cycle 101.
- 8E2, same clocking, send 8'hEF (7 ones) → parity bit 1, two stop bits. 8O1 → parity bit 0. Frame lengths 12·10 and 11·10 cycles.
- 5N1 with 8'hxx_1F applied to a 5-bit port, 9N1 with 9'h1AA → exactly DATA_BITS data periods, LSB first.
- `tx_valid` held high for 3 words A5, 3C, FF → three contiguous frames with exactly one idle clock between each. Data changed mid-frame does not corrupt the frame.
- `rst_n` low for 1 cycle during data bit 3 → `txd=1` next edge, no `tx_done`, `tx_ready=1` after release. A new word then transmits correctly.
- Default parameters: measure the start bit width = 10417 cycles and 9600-baud framing of 8'hEF.
